// File: rtl/pl_pipe_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core.
// Generates stall/flush controls for the F/D, D/E, E/M and M/W registers from
// data-memory handshake stalls, taken branches/jumps and load-use hazards.
// It also holds the memory handshake FSM, a bus timeout with a sticky error
// flag, and a saturating counter of memory-stall cycles.
module pl_pipe_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemReqM,
    input  logic             DMemAck,
    input  logic [1:0]       ResultSrcE,
    input  logic [4:0]       RdE,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic             PCSrcE,
    output logic             DMemReq,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemBusErr,
    output logic [CNT_W-1:0] StallCnt
);

    // The wait counter only ever reaches TIMEOUT_CYC-1 before leaving WAIT.
    localparam int unsigned WAIT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]        RES_LOAD  = 2'b01;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    logic mem_stall;
    logic timeout;
    logic load_use;

    // Memory stall and timeout decode from the handshake state.
    always_comb begin
        mem_stall = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                mem_stall = MemReqM & ~DMemAck;
            end
            S_WAIT: begin
                timeout   = ~DMemAck && (wait_cnt == WAIT_LAST);
                mem_stall = ~DMemAck && !timeout;
            end
            default: begin
                mem_stall = 1'b0;
                timeout   = 1'b0;
            end
        endcase
    end

    // Load in E whose destination feeds a D-stage source; x0 never hazards.
    always_comb begin
        load_use = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));
    end

    // Pipeline controls: reset bubbles, then memory stall > branch > load-use.
    always_comb begin
        DMemReq = 1'b0;
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        StallM  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        FlushW  = 1'b0;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            DMemReq = (state == S_WAIT) | MemReqM;
            if (mem_stall) begin
                // E is frozen, so branch and load-use re-evaluate after release.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                // An aborted access must not write back.
                FlushW = timeout;
                if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (load_use) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
        end
    end

    // Handshake FSM, wait counter and sticky bus-error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            MemBusErr <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (MemReqM && !DMemAck) begin
                        state    <= S_WAIT;
                        wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (DMemAck) begin
                        state <= S_IDLE;
                    end else if (timeout) begin
                        state     <= S_IDLE;
                        MemBusErr <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Saturating count of cycles with the E/M register held.
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCnt <= '0;
        end else if (StallM && (StallCnt != {CNT_W{1'b1}})) begin
            StallCnt <= StallCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pl_pipe_ctrl.sv
// Directed bench for pl_pipe_ctrl. Inputs change just after the falling edge;
// the combinational controls are sampled 1ns later, well away from posedge.
module tb_pl_pipe_ctrl;

    logic       clk;
    logic       reset;
    logic       MemReqM;
    logic       DMemAck;
    logic [1:0] ResultSrcE;
    logic [4:0] RdE;
    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic       PCSrcE;

    logic        DMemReq, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic        MemBusErr;
    logic [15:0] StallCnt;

    logic        b_DMemReq, b_StallF, b_StallD, b_StallE, b_StallM;
    logic        b_FlushD, b_FlushE, b_FlushW, b_MemBusErr;
    logic [1:0]  b_StallCnt;

    // {DMemReq, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    logic [7:0] ctl;
    assign ctl = {DMemReq, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    localparam logic [7:0] C_NONE   = 8'b0_0000_000;
    localparam logic [7:0] C_RST    = 8'b0_0000_111;
    localparam logic [7:0] C_REQ    = 8'b1_0000_000;
    localparam logic [7:0] C_MSTALL = 8'b1_1111_001;
    localparam logic [7:0] C_LU     = 8'b0_1100_010;
    localparam logic [7:0] C_BR     = 8'b0_0000_110;
    localparam logic [7:0] C_REQ_BR = 8'b1_0000_110;
    localparam logic [7:0] C_ABORT  = 8'b1_0000_001;

    int total;
    int bad;

    pl_pipe_ctrl #(.TIMEOUT_CYC(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .MemReqM(MemReqM), .DMemAck(DMemAck),
        .ResultSrcE(ResultSrcE), .RdE(RdE), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .PCSrcE(PCSrcE), .DMemReq(DMemReq), .StallF(StallF), .StallD(StallD),
        .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE),
        .FlushW(FlushW), .MemBusErr(MemBusErr), .StallCnt(StallCnt)
    );

    pl_pipe_ctrl #(.TIMEOUT_CYC(255), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .MemReqM(MemReqM), .DMemAck(DMemAck),
        .ResultSrcE(ResultSrcE), .RdE(RdE), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .PCSrcE(PCSrcE), .DMemReq(b_DMemReq), .StallF(b_StallF), .StallD(b_StallD),
        .StallE(b_StallE), .StallM(b_StallM), .FlushD(b_FlushD), .FlushE(b_FlushE),
        .FlushW(b_FlushW), .MemBusErr(b_MemBusErr), .StallCnt(b_StallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        MemReqM    = 1'b0;
        DMemAck    = 1'b0;
        ResultSrcE = 2'b00;
        RdE        = 5'd0;
        Rs1D       = 5'd0;
        Rs2D       = 5'd0;
        PCSrcE     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        #1;
        total++;
        if (ctl !== C_RST) begin
            bad++;
            $display("FAIL reset_ctl: got %b want %b", ctl, C_RST);
        end
        step();
        #1;
        total++;
        if (StallCnt !== 16'd0 || MemBusErr !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: cnt=%0d err=%b want 0/0", StallCnt, MemBusErr);
        end
        reset = 1'b0;
        #1;
        total++;
        if (ctl !== C_NONE) begin
            bad++;
            $display("FAIL post_reset_idle: got %b want %b", ctl, C_NONE);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        MemReqM = 1'b1;
        DMemAck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ctl !== C_REQ) begin
                bad++;
                $display("FAIL zero_wait_c%0d: got %b want %b", i, ctl, C_REQ);
            end
            step();
        end
        idle_inputs();
        #1;
        total++;
        if (StallCnt !== 16'd0) begin
            bad++;
            $display("FAIL zero_wait_cnt: got %0d want 0", StallCnt);
        end
    endtask

    task automatic test_ack3();
        do_reset();
        MemReqM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ctl !== C_MSTALL) begin
                bad++;
                $display("FAIL ack3_stall_c%0d: got %b want %b", i, ctl, C_MSTALL);
            end
            step();
        end
        DMemAck = 1'b1;
        #1;
        total++;
        if (ctl !== C_REQ) begin
            bad++;
            $display("FAIL ack3_release: got %b want %b", ctl, C_REQ);
        end
        step();
        idle_inputs();
        #1;
        total++;
        if (ctl !== C_NONE || StallCnt !== 16'd3) begin
            bad++;
            $display("FAIL ack3_after: ctl=%b cnt=%0d want %b/3", ctl, StallCnt, C_NONE);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd1;
        #1;
        total++;
        if (ctl !== C_LU) begin
            bad++;
            $display("FAIL lu_rs1: got %b want %b", ctl, C_LU);
        end
        step();
        ResultSrcE = 2'b00; RdE = 5'd6; Rs1D = 5'd7; Rs2D = 5'd8;
        #1;
        total++;
        if (ctl !== C_NONE) begin
            bad++;
            $display("FAIL lu_one_cycle: got %b want %b", ctl, C_NONE);
        end
        step();
        ResultSrcE = 2'b01; RdE = 5'd9; Rs1D = 5'd2; Rs2D = 5'd9;
        #1;
        total++;
        if (ctl !== C_LU) begin
            bad++;
            $display("FAIL lu_rs2: got %b want %b", ctl, C_LU);
        end
        step();
        ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
        #1;
        total++;
        if (ctl !== C_NONE) begin
            bad++;
            $display("FAIL lu_x0: got %b want %b", ctl, C_NONE);
        end
        step();
        ResultSrcE = 2'b00; RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd5;
        #1;
        total++;
        if (ctl !== C_NONE) begin
            bad++;
            $display("FAIL lu_not_load: got %b want %b", ctl, C_NONE);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5; PCSrcE = 1'b1;
        #1;
        total++;
        if (ctl !== C_BR) begin
            bad++;
            $display("FAIL br_over_lu: got %b want %b", ctl, C_BR);
        end
        step();
        idle_inputs();
        MemReqM = 1'b1; PCSrcE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (ctl !== C_MSTALL) begin
                bad++;
                $display("FAIL br_in_wait_c%0d: got %b want %b", i, ctl, C_MSTALL);
            end
            step();
        end
        DMemAck = 1'b1;
        #1;
        total++;
        if (ctl !== C_REQ_BR) begin
            bad++;
            $display("FAIL br_at_ack: got %b want %b", ctl, C_REQ_BR);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        MemReqM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (ctl !== C_MSTALL) begin
                bad++;
                $display("FAIL to_stall_c%0d: got %b want %b", i, ctl, C_MSTALL);
            end
            step();
        end
        #1;
        total++;
        if (ctl !== C_ABORT || MemBusErr !== 1'b0) begin
            bad++;
            $display("FAIL to_abort: ctl=%b err=%b want %b/0", ctl, MemBusErr, C_ABORT);
        end
        step();
        idle_inputs();
        #1;
        total++;
        if (ctl !== C_NONE || MemBusErr !== 1'b1 || StallCnt !== 16'd4) begin
            bad++;
            $display("FAIL to_after: ctl=%b err=%b cnt=%0d want %b/1/4",
                     ctl, MemBusErr, StallCnt, C_NONE);
        end
        step();
        MemReqM = 1'b1;
        #1;
        total++;
        if (ctl !== C_MSTALL) begin
            bad++;
            $display("FAIL to_next_req: got %b want %b", ctl, C_MSTALL);
        end
        step();
        DMemAck = 1'b1;
        #1;
        total++;
        if (ctl !== C_REQ) begin
            bad++;
            $display("FAIL to_next_ack: got %b want %b", ctl, C_REQ);
        end
        step();
        idle_inputs();
        #1;
        total++;
        if (MemBusErr !== 1'b1 || StallCnt !== 16'd5 || ctl !== C_NONE) begin
            bad++;
            $display("FAIL to_sticky: err=%b cnt=%0d ctl=%b want 1/5/%b",
                     MemBusErr, StallCnt, ctl, C_NONE);
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        MemReqM = 1'b1;
        step();
        step();
        reset = 1'b1;
        #1;
        total++;
        if (ctl !== C_RST) begin
            bad++;
            $display("FAIL rw_during: got %b want %b", ctl, C_RST);
        end
        step();
        reset   = 1'b0;
        MemReqM = 1'b0;
        #1;
        total++;
        if (ctl !== C_NONE || StallCnt !== 16'd0) begin
            bad++;
            $display("FAIL rw_after: ctl=%b cnt=%0d want %b/0", ctl, StallCnt, C_NONE);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_saturate();
        do_reset();
        MemReqM = 1'b1;
        for (int i = 0; i < 3; i++) step();
        #1;
        total++;
        if (b_StallCnt !== 2'd3) begin
            bad++;
            $display("FAIL sat_reach: got %0d want 3", b_StallCnt);
        end
        step();
        step();
        DMemAck = 1'b1;
        step();
        idle_inputs();
        #1;
        total++;
        if (b_StallCnt !== 2'd3) begin
            bad++;
            $display("FAIL sat_hold: got %0d want 3", b_StallCnt);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_zero_wait();
        test_ack3();
        test_load_use();
        test_branch();
        test_timeout();
        test_reset_in_wait();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
